bs_gnrtr_n_rbtr_rr: RTL and testbench

Parametrised successor bus generator/arbiter for the multi-device bus environment. It polls drvrs source FIFOs, grants one per transaction using a runtime-selectable round-robin or fixed-priority policy, and routes the packet by its 8-bit destination ID (unicast or broadcast). It also supports per-destination backpressure, a stall timeout, invalid-ID error reporting and a transfer counter. It sits between the device FIFO models (driver/monitor side) and replaces the single-policy arbiter.

---
 rtl/bs_gnrtr_n_rbtr_rr.sv | 110 +++++++++++
 tb/tb_bs_gnrtr_n_rbtr_rr.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bs_gnrtr_n_rbtr_rr.sv
// bs_gnrtr_n_rbtr_rr: bus arbiter, round-robin or fixed-priority grant, routes each packet by its destination ID
// clk, reset (async, active-low), arb_mode (0 rr, 1 fixed lowest-index)
// pndng/D_pop/pop: source FIFO side; full/push/D_push: destination FIFO side
// err: one-cycle drop pulse (bad ID or stall timeout); pkt_cnt: delivered packet count
module bs_gnrtr_n_rbtr_rr #(
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int stall_max = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arb_mode,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  input  logic [drvrs-1:0]         full,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     err,
  output logic [15:0]              pkt_cnt
);
  localparam int IW = $clog2(drvrs);
  localparam int SW = $clog2(stall_max + 1);
  typedef enum logic {IDLE, ROUTE} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, src, src_n, g_fix, g_rr, g, j;
  logic [pckg_sz-1:0] pkt, pkt_n, D_push_n;
  logic [SW-1:0] stall, stall_n;
  logic [drvrs-1:0] pop_n, push_n, tgt;
  logic [15:0] cnt_n;
  logic [7:0] id;
  logic err_n, vld, blk;
  always_comb begin
    g_fix = '0;
    g_rr = '0;
    j = '0;
    // descending scan so the smallest offset from the pointer wins
    for (int i = drvrs - 1; i >= 0; i--) begin
      if (pndng[i]) g_fix = IW'(i);
      j = (int'(ptr) + i >= drvrs) ? IW'(int'(ptr) + i - drvrs) : IW'(int'(ptr) + i);
      if (pndng[j]) g_rr = j;
    end
  end
  assign g = arb_mode ? g_fix : g_rr;
  assign id = pkt[pckg_sz-1 -: 8];
  assign vld = (id == broadcast) || (32'(id) < drvrs);
  assign tgt = (id == broadcast) ? ~(drvrs'(1) << src) : drvrs'(1) << id;
  assign blk = |(full & tgt);
  always_comb begin
    state_n = state;
    pop_n = '0;
    push_n = '0;
    D_push_n = D_push;
    err_n = 1'b0;
    cnt_n = pkt_cnt;
    ptr_n = ptr;
    src_n = src;
    pkt_n = pkt;
    stall_n = stall;
    if (state == IDLE) begin
      if (|pndng) begin
        pop_n = drvrs'(1) << g;
        pkt_n = D_pop[int'(g)*pckg_sz +: pckg_sz];
        src_n = g;
        stall_n = '0;
        ptr_n = (g == IW'(drvrs - 1)) ? '0 : g + 1'b1;
        state_n = ROUTE;
      end
    end else if (!vld) begin
      err_n = 1'b1;
      state_n = IDLE;
    end else if (!blk) begin
      push_n = tgt;
      D_push_n = pkt;
      cnt_n = pkt_cnt + 16'd1;
      state_n = IDLE;
    end else if (stall == SW'(stall_max - 1)) begin
      err_n = 1'b1;
      state_n = IDLE;
    end else begin
      stall_n = stall + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pop <= '0;
      push <= '0;
      D_push <= '0;
      err <= 1'b0;
      pkt_cnt <= '0;
      ptr <= '0;
      src <= '0;
      pkt <= '0;
      stall <= '0;
    end else begin
      state <= state_n;
      pop <= pop_n;
      push <= push_n;
      D_push <= D_push_n;
      err <= err_n;
      pkt_cnt <= cnt_n;
      ptr <= ptr_n;
      src <= src_n;
      pkt <= pkt_n;
      stall <= stall_n;
    end
  end
endmodule

// File: tb/tb_bs_gnrtr_n_rbtr_rr.sv
// tb_bs_gnrtr_n_rbtr_rr: directed bench for the bus arbiter, default instance plus a stall_max=4 instance
module tb_bs_gnrtr_n_rbtr_rr;
  logic clk = 1'b0, reset = 1'b0, arb_mode = 1'b0;
  logic [3:0] pndng = '0, full = '0;
  logic [63:0] D_pop = '0;
  logic [3:0] pop, push, pop4, push4;
  logic [15:0] D_push, D_push4, cnt, cnt4;
  logic err, err4;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  bs_gnrtr_n_rbtr_rr dut (
    .clk(clk), .reset(reset), .arb_mode(arb_mode), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .full(full), .push(push), .D_push(D_push), .err(err), .pkt_cnt(cnt)
  );
  bs_gnrtr_n_rbtr_rr #(.stall_max(4)) dut4 (
    .clk(clk), .reset(reset), .arb_mode(arb_mode), .pndng(pndng), .D_pop(D_pop),
    .pop(pop4), .full(full), .push(push4), .D_push(D_push4), .err(err4), .pkt_cnt(cnt4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic rst_pulse();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic grant(input int s, input logic [15:0] w);
    D_pop[s*16 +: 16] = w;
    pndng = 4'b0001 << s;
    @(negedge clk);
    chk("grant_pop", pop, 4'b0001 << s);
    pndng = '0;
  endtask
  initial begin
    #2;
    chk("rst_pop", pop, 0);
    chk("rst_push", push, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_dpush", D_push, 0);
    @(negedge clk);
    reset = 1'b1;
    grant(1, 16'h0234);
    @(negedge clk);
    chk("uni_pop", pop, 0);
    chk("uni_push", push, 4'b0100);
    chk("uni_data", D_push, 16'h0234);
    chk("uni_cnt", cnt, 1);
    @(negedge clk);
    chk("uni_push_off", push, 0);
    chk("uni_data_hold", D_push, 16'h0234);
    rst_pulse();
    for (int i = 0; i < 4; i++) D_pop[i*16 +: 16] = {8'((i + 1) % 4), 8'(i)};
    pndng = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_pop", pop, 1 << (k % 4));
      @(negedge clk);
      chk("rr_push", push, 1 << ((k % 4 + 1) % 4));
    end
    arb_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fp_pop", pop, 4'b0001);
      @(negedge clk);
      chk("fp_push", push, 4'b0010);
    end
    pndng = '0;
    arb_mode = 1'b0;
    rst_pulse();
    grant(2, 16'hFF5A);
    @(negedge clk);
    chk("bc_push", push, 4'b1011);
    chk("bc_data", D_push, 16'hFF5A);
    chk("bc_cnt", cnt, 1);
    rst_pulse();
    full = 4'b1000;
    grant(0, 16'h0311);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_push", push, 0);
      chk("bp_err", err, 0);
    end
    full = '0;
    @(negedge clk);
    chk("bp_release", push, 4'b1000);
    chk("bp_err_end", err, 0);
    chk("bp_cnt", cnt, 1);
    grant(0, 16'h0311);
    reset = 1'b0;
    #1;
    chk("ar_pop", pop, 0);
    chk("ar_cnt", cnt, 0);
    chk("ar_push", push, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ar_lost_push", push, 0);
    chk("ar_lost_cnt", cnt, 0);
    grant(1, 16'h0700);
    @(negedge clk);
    chk("inv_err", err, 1);
    chk("inv_push", push, 0);
    chk("inv_cnt", cnt, 0);
    @(negedge clk);
    chk("inv_err_off", err, 0);
    rst_pulse();
    full = 4'b1000;
    grant(0, 16'h0311);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("to_wait_err", err4, 0);
    end
    @(negedge clk);
    chk("to_err", err4, 1);
    chk("to_push", push4, 0);
    @(negedge clk);
    chk("to_err_off", err4, 0);
    chk("to_cnt", cnt4, 0);
    full = '0;
    rst_pulse();
    force dut.pkt_cnt = 16'hFFFF;
    #1;
    release dut.pkt_cnt;
    @(negedge clk);
    chk("wrap_pre", cnt, 16'hFFFF);
    grant(0, 16'h0311);
    @(negedge clk);
    chk("wrap_push", push, 4'b1000);
    chk("wrap_cnt", cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
